// File: rtl/disp_pkg.sv
// Shared seven-segment definitions: active-low segment bit order and a hex
// glyph helper for callers that want to build patterns for the display bank.
package disp_pkg;

   localparam logic [7:0] SSEG_OFF = 8'hFF;

   // Bit positions within an active-low pattern {dp,g,f,e,d,c,b,a}
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   function automatic logic [7:0] hex_to_sseg(input logic [3:0] hex);
      logic [7:0] seg;
      case (hex)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/disp_scan_timer.sv
// Digit scan timebase: slot counter, digit select and a registered pulse
// marking the wrap from the last digit back to digit 0.
module disp_scan_timer
   import disp_pkg::*;
#(
   parameter int N_DIG    = 4,
   parameter int DIG_BITS = 16,
   localparam int AW      = $clog2(N_DIG)
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [DIG_BITS-1:0] cnt_o,
   output logic [AW-1:0]       sel_o,
   output logic                frame_tick_o
);

   localparam logic [DIG_BITS-1:0] CNT_MAX = '1;
   localparam logic [AW-1:0]       SEL_MAX = AW'(N_DIG - 1);

   logic [DIG_BITS-1:0] cnt_q, cnt_d;
   logic [AW-1:0]       sel_q, sel_d;
   logic                tick_q, tick_d;

   // sel only moves on slot terminal count; N_DIG need not be a power of two
   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      sel_d  = sel_q;
      tick_d = 1'b0;
      if (cnt_q == CNT_MAX) begin
         if (sel_q == SEL_MAX) begin
            sel_d  = '0;
            tick_d = 1'b1;
         end else begin
            sel_d  = sel_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         sel_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sel_q  <= sel_d;
         tick_q <= tick_d;
      end
   end

   assign cnt_o        = cnt_q;
   assign sel_o        = sel_q;
   assign frame_tick_o = tick_q;

endmodule

// File: rtl/disp_mux_bank.sv
// N-digit multiplexed seven-segment driver with an internal pattern bank,
// per-digit blanking, PWM brightness and anti-ghosting dead time.
module disp_mux_bank
   import disp_pkg::*;
#(
   parameter int N_DIG       = 4,
   parameter int DIG_BITS    = 16,
   parameter int DUTY_BITS   = 4,
   parameter int DEAD_CYCLES = 4,
   localparam int AW         = $clog2(N_DIG)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [7:0]           wdata,
   input  logic [N_DIG-1:0]     blank_mask,
   input  logic [DUTY_BITS-1:0] duty,
   output logic [N_DIG-1:0]     an,
   output logic [7:0]           sseg,
   output logic                 frame_tick
);

   localparam logic [DUTY_BITS-1:0] DUTY_FULL = '1;
   localparam logic [DIG_BITS-1:0]  DEAD_CNT  = DIG_BITS'(DEAD_CYCLES);

   logic [DIG_BITS-1:0]  cnt;
   logic [AW-1:0]        sel;
   logic [DUTY_BITS-1:0] phase;
   logic                 lit;

   logic [7:0]       pat_q [N_DIG];
   logic [N_DIG-1:0] an_q, an_d;
   logic [7:0]       sseg_q, sseg_d;

   disp_scan_timer #(
      .N_DIG    (N_DIG),
      .DIG_BITS (DIG_BITS)
   ) u_timer (
      .clk          (clk),
      .rst_n        (reset),
      .cnt_o        (cnt),
      .sel_o        (sel),
      .frame_tick_o (frame_tick)
   );

   // Out-of-range addresses are dropped so a wide host bus cannot alias digits
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_DIG; i++) begin
            pat_q[i] <= SSEG_OFF;
         end
      end else if (we && (int'(waddr) < N_DIG)) begin
         pat_q[waddr] <= wdata;
      end
   end

   assign phase = cnt[DIG_BITS-1 -: DUTY_BITS];
   assign lit   = !blank_mask[sel] && (cnt >= DEAD_CNT) &&
                  ((duty == DUTY_FULL) || (phase < duty));

   // A single lit bit shifted into place keeps the anodes one-hot by construction
   always_comb begin
      an_d   = ~(N_DIG'(lit) << sel);
      sseg_d = lit ? pat_q[sel] : SSEG_OFF;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an_q   <= '1;
         sseg_q <= SSEG_OFF;
      end else begin
         an_q   <= an_d;
         sseg_q <= sseg_d;
      end
   end

   assign an   = an_q;
   assign sseg = sseg_q;

endmodule

// File: tb/tb_disp_mux_bank.sv
// Scoreboard bench for disp_mux_bank: a cycle-level reference model queues the
// expected outputs and a negedge monitor pops and compares them.
module tb_disp_mux_bank;
   localparam int N_DIG       = 3;
   localparam int DIG_BITS    = 4;
   localparam int DUTY_BITS   = 2;
   localparam int DEAD_CYCLES = 1;
   localparam int AW          = 2;
   localparam int SLOT        = 1 << DIG_BITS;
   localparam int FRAME       = N_DIG * SLOT;
   localparam int STEPS       = 1 << DUTY_BITS;

   logic                 clk        = 1'b0;
   logic                 reset      = 1'b0;
   logic                 we         = 1'b0;
   logic [AW-1:0]        waddr      = '0;
   logic [7:0]           wdata      = '0;
   logic [N_DIG-1:0]     blank_mask = '0;
   logic [DUTY_BITS-1:0] duty       = '1;
   logic [N_DIG-1:0]     an;
   logic [7:0]           sseg;
   logic                 frame_tick;

   int total = 0;
   int bad   = 0;

   logic [11:0] exp_q[$];
   int          m_t = 0;
   logic [7:0]  m_pat [N_DIG];

   disp_mux_bank #(
      .N_DIG       (N_DIG),
      .DIG_BITS    (DIG_BITS),
      .DUTY_BITS   (DUTY_BITS),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .blank_mask (blank_mask),
      .duty       (duty),
      .an         (an),
      .sseg       (sseg),
      .frame_tick (frame_tick)
   );

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < N_DIG; i++) m_pat[i] = 8'hFF;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: time since reset gives digit and slot position directly
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_t = 0;
         for (int i = 0; i < N_DIG; i++) m_pat[i] = 8'hFF;
         exp_q.delete();
      end else begin
         int               c;
         int               s;
         bit               on;
         logic [N_DIG-1:0] a;
         logic [7:0]       sg;
         c  = m_t % SLOT;
         s  = (m_t / SLOT) % N_DIG;
         on = !blank_mask[s] && (c >= DEAD_CYCLES) &&
              ((int'(duty) == STEPS - 1) || ((c * STEPS) / SLOT < int'(duty)));
         a  = '1;
         if (on) a[s] = 1'b0;
         sg = on ? m_pat[s] : 8'hFF;
         exp_q.push_back({(c == SLOT - 1) && (s == N_DIG - 1), a, sg});
         m_t++;
         if (we && int'(waddr) < N_DIG) m_pat[waddr] = wdata;
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (reset && exp_q.size() > 0) begin
         logic [11:0] e;
         e = exp_q.pop_front();
         chk("frame_tick", frame_tick, e[11]);
         chk("an", an, e[10:8]);
         chk("sseg", sseg, e[7:0]);
         chk("an_onehot", ($countones(~an) <= 1), 1);
      end
   end

   // Driver tasks
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
      we = 1'b1; waddr = a; wdata = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic wait_an(input logic [N_DIG-1:0] target, input string name);
      int n;
      n = 0;
      while (an !== target && n < 4 * FRAME) begin
         @(negedge clk);
         n++;
      end
      chk(name, an, target);
   endtask

   initial begin
      cyc(2);
      #1;
      chk("rst_an", an, 3'b111);
      chk("rst_sseg", sseg, 8'hFF);
      chk("rst_tick", frame_tick, 0);
      @(negedge clk);
      reset = 1'b1;

      wr(0, 8'hC0); wr(1, 8'hF9); wr(2, 8'hA4);
      cyc(2 * FRAME);

      duty = 2'b01;  cyc(FRAME);
      duty = 2'b00;  cyc(FRAME);
      duty = 2'b11; blank_mask = 3'b010; cyc(FRAME);
      blank_mask = '0;

      wait_an(3'b101, "wait_dig1");
      wr(1, 8'h80);
      chk("wr_old_cycle", sseg, 8'hF9);
      @(negedge clk);
      chk("wr_new_cycle", sseg, 8'h80);
      cyc(FRAME);

      wr(2'd3, 8'h00);
      cyc(FRAME);

      repeat (400) begin
         duty = DUTY_BITS'($urandom_range(0, STEPS - 1));
         if ($urandom_range(0, 7) == 0) blank_mask = N_DIG'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) begin
            we    = 1'b1;
            waddr = AW'($urandom_range(0, 3));
            wdata = 8'($urandom_range(0, 255));
         end else begin
            we = 1'b0;
         end
         @(negedge clk);
      end
      we = 1'b0; duty = 2'b11; blank_mask = '0;

      wait_an(3'b011, "wait_dig2");
      cyc(3);
      #2 reset = 1'b0;
      #1;
      chk("midrst_an", an, 3'b111);
      chk("midrst_sseg", sseg, 8'hFF);
      chk("midrst_tick", frame_tick, 0);
      cyc(2);
      reset = 1'b1;
      @(negedge clk);
      chk("rel_dead", an, 3'b111);
      @(negedge clk);
      chk("rel_first_an", an, 3'b110);
      chk("rel_pat_cleared", sseg, 8'hFF);

      wr(0, 8'h92); wr(1, 8'h99); wr(2, 8'hB0);
      cyc(FRAME + 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
